// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-register scoreboard, stall/bubble/flush and HALT drain.
// Optional build macro HAZARD_FORWARD_EN selects EX/MEM forwarding (load-use stalls only).
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [2:0]  dec_rs,
  input  logic [2:0]  dec_rt,
  input  logic        dec_rs_used,
  input  logic        dec_rt_used,
  input  logic [2:0]  dec_wr_reg,
  input  logic        dec_reg_write,
  input  logic        dec_mem_read,
  input  logic        dec_halt,
  input  logic        dec_redirect,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [7:0][1:0] cnt;
  logic [7:0]      ld;
  logic            rs_pend;
  logic            rt_pend;
  logic            hazard;
  logic            issue;
  logic            all_clear;

  // cnt==1 means the producer is in WB; the register file bypass makes it readable.
  always_comb begin
`ifdef HAZARD_FORWARD_EN
    rs_pend = dec_rs_used && (cnt[dec_rs] == 2'd3) && ld[dec_rs];
    rt_pend = dec_rt_used && (cnt[dec_rt] == 2'd3) && ld[dec_rt];
`else
    rs_pend = dec_rs_used && (cnt[dec_rs] >= 2'd2);
    rt_pend = dec_rt_used && (cnt[dec_rt] >= 2'd2);
`endif
  end

  always_comb begin
    hazard = dec_valid && (state == ST_RUN) && (rs_pend || rt_pend);
    stall  = hazard || (state != ST_RUN);
    bubble = stall;
    issue  = dec_valid && !stall;
    flush  = issue && dec_redirect;
  end

  always_comb begin
    all_clear = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (cnt[i] != 2'd0) all_clear = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (issue && dec_halt) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (all_clear) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == ST_HALTED);
    end
  end

  // A reload on issue takes priority over the countdown for the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ld  <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (issue && dec_reg_write && (dec_wr_reg == 3'(i))) begin
          cnt[i] <= 2'd3;
          ld[i]  <= dec_mem_read;
        end else if (cnt[i] != 2'd0) begin
          cnt[i] <= cnt[i] - 2'd1;
          if (cnt[i] == 2'd1) ld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (stall && (state == ST_RUN) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
